// File: rtl/cnn_inference_sequencer.sv
// CNN inference control: convolution -> max-pool -> dense capture -> serial argmax -> done.
// Optional convolution watchdog (ERROR state, error flag) is built when CNN_SEQ_WATCHDOG_EN is defined.
module cnn_inference_sequencer #(
  parameter int CLASS_COUNT    = 10,
  parameter int SCORE_BIT      = 35,
  parameter int CLASS_BIT      = 4,
  parameter int POOL_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_BIT    = 13
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             conv_done,
  input  logic [CLASS_COUNT*SCORE_BIT-1:0] scores,
  output logic                             conv_enable,
  output logic                             pool_enable,
  output logic                             busy,
  output logic                             done,
  output logic [CLASS_BIT-1:0]             result_class,
  output logic signed [SCORE_BIT-1:0]      result_score,
  output logic                             error
);
  localparam int POOL_BIT = (POOL_CYCLES > 1) ? $clog2(POOL_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_POOL, S_DENSE, S_ARGMAX, S_DONE
`ifdef CNN_SEQ_WATCHDOG_EN
    , S_ERROR
`endif
  } state_t;

  if (POOL_CYCLES < 1 || CLASS_COUNT < 2) begin : g_bad_cfg
    $error("cnn_inference_sequencer: need POOL_CYCLES >= 1 and CLASS_COUNT >= 2");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_BIT < 1 || (TIMEOUT_CYCLES >> TIMEOUT_BIT) != 0) begin : g_bad_wd
    $error("cnn_inference_sequencer: TIMEOUT_BIT too narrow or TIMEOUT_CYCLES < 2");
  end

  state_t                       state, state_next;
  logic [POOL_BIT-1:0]          pool_cnt;
  logic [CLASS_BIT-1:0]         arg_idx;
  logic [CLASS_BIT-1:0]         max_class;
  logic signed [SCORE_BIT-1:0]  max_score;
  logic signed [SCORE_BIT-1:0]  bank [CLASS_COUNT];
  logic signed [SCORE_BIT-1:0]  cand_score;
  logic                         cand_wins;
`ifdef CNN_SEQ_WATCHDOG_EN
  logic [TIMEOUT_BIT-1:0]       wd_cnt;
  logic                         error_q;
`endif

  // Strictly-greater signed compare: ties keep the earlier (lower) class index.
  function automatic logic beats(input logic signed [SCORE_BIT-1:0] cand,
                                 input logic signed [SCORE_BIT-1:0] best);
    return cand > best;
  endfunction

  assign cand_score = bank[arg_idx];
  assign cand_wins  = beats(cand_score, max_score);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_CONV;
      S_CONV: begin
        if (conv_done) state_next = S_POOL;
`ifdef CNN_SEQ_WATCHDOG_EN
        else if (wd_cnt == TIMEOUT_BIT'(TIMEOUT_CYCLES - 1)) state_next = S_ERROR;
`endif
      end
      S_POOL:   if (pool_cnt == '0) state_next = S_DENSE;
      S_DENSE:  state_next = S_ARGMAX;
      S_ARGMAX: if (arg_idx == CLASS_BIT'(CLASS_COUNT - 1)) state_next = S_DONE;
`ifdef CNN_SEQ_WATCHDOG_EN
      S_ERROR:  state_next = S_DONE;
`endif
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are flops aligned with the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      pool_cnt     <= '0;
      arg_idx      <= '0;
      max_class    <= '0;
      max_score    <= '0;
      conv_enable  <= 1'b0;
      pool_enable  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_class <= '0;
      result_score <= '0;
      for (int i = 0; i < CLASS_COUNT; i++) bank[i] <= '0;
    end else begin
      state       <= state_next;
      conv_enable <= (state_next == S_CONV);
      pool_enable <= (state_next == S_POOL);
      busy        <= (state_next != S_IDLE);
      done        <= (state_next == S_DONE);
      case (state)
        S_CONV:  pool_cnt <= POOL_BIT'(POOL_CYCLES - 1);
        S_POOL:  if (pool_cnt != '0) pool_cnt <= pool_cnt - 1'b1;
        S_DENSE: begin
          for (int i = 0; i < CLASS_COUNT; i++) bank[i] <= scores[i*SCORE_BIT +: SCORE_BIT];
          max_score <= scores[SCORE_BIT-1:0];
          max_class <= '0;
          arg_idx   <= CLASS_BIT'(1);
        end
        S_ARGMAX: begin
          arg_idx <= arg_idx + 1'b1;
          if (cand_wins) begin
            max_score <= cand_score;
            max_class <= arg_idx;
          end
          if (state_next == S_DONE) begin
            result_class <= cand_wins ? arg_idx : max_class;
            result_score <= cand_wins ? cand_score : max_score;
          end
        end
`ifdef CNN_SEQ_WATCHDOG_EN
        S_ERROR: begin
          result_class <= '0;
          result_score <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef CNN_SEQ_WATCHDOG_EN
  // Watchdog counts consecutive CONV cycles; error is sticky until the next accepted start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == S_CONV) wd_cnt <= wd_cnt + 1'b1;
      else                 wd_cnt <= '0;
      if (state == S_IDLE && start) error_q <= 1'b0;
      else if (state == S_ERROR)    error_q <= 1'b1;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_inference_sequencer.sv
// Bench for cnn_inference_sequencer: table vectors, randomized scores against an argmax model,
// and hand-written sequences for back-to-back starts, mid-run reset and the optional watchdog.
module tb_cnn_inference_sequencer;
  localparam int CC  = 10;
  localparam int SB  = 35;
  localparam int CB  = 4;
  localparam int PC  = 2;
  localparam int TC  = 4096;
  localparam int TBW = 13;
  localparam int BUS = CC * SB;
  localparam int LAT = PC + CC + 1;
  localparam longint SMAX = (longint'(1) <<< (SB - 1)) - 1;
  localparam longint SMIN = -SMAX - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic conv_done = 1'b0;
  logic [BUS-1:0] scores = '0;
  logic conv_enable, pool_enable, busy, done, error;
  logic [CB-1:0] result_class;
  logic signed [SB-1:0] result_score;

  int tests = 0;
  int fails = 0;
  int overlap = 0;
  int done_cnt = 0;

  typedef struct {
    logic [BUS-1:0] bus;
    int             cls;
    longint         score;
  } vec_t;
  vec_t tbl[5];

  cnn_inference_sequencer #(
    .CLASS_COUNT(CC), .SCORE_BIT(SB), .CLASS_BIT(CB), .POOL_CYCLES(PC),
    .TIMEOUT_CYCLES(TC), .TIMEOUT_BIT(TBW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .conv_done(conv_done), .scores(scores),
    .conv_enable(conv_enable), .pool_enable(pool_enable), .busy(busy), .done(done),
    .result_class(result_class), .result_score(result_score), .error(error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (conv_enable && pool_enable) overlap++;
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [BUS-1:0] pack(input longint v[CC]);
    logic [BUS-1:0] b;
    b = '0;
    for (int i = 0; i < CC; i++) b[i*SB +: SB] = SB'(v[i]);
    return b;
  endfunction

  // Reference: first index holding the largest signed value.
  function automatic void ref_argmax(input logic [BUS-1:0] b, output int cls, output longint sc);
    longint v;
    cls = 0;
    sc  = longint'($signed(b[SB-1:0]));
    for (int i = 1; i < CC; i++) begin
      v = longint'($signed(b[i*SB +: SB]));
      if (v > sc) begin
        sc  = v;
        cls = i;
      end
    end
  endfunction

  function automatic longint rnd_score();
    logic [63:0] r;
    case ($urandom_range(0, 3))
      0:       return longint'($urandom_range(0, 6)) - 3;
      1:       return ($urandom_range(0, 1) != 0) ? SMAX : SMIN;
      default: begin
        r = {$urandom, $urandom};
        return longint'($signed(r[SB-1:0]));
      end
    endcase
  endfunction

  task automatic run_one(input logic [BUS-1:0] bus, input int cls, input longint sc,
                         input int conv_wait, input bit change);
    int n;
    scores = bus;
    start  = 1'b1;
    step();
    start = 1'b0;
    check("conv_enable_on_start", conv_enable, 1);
    check("error_clear_on_start", error, 0);
    repeat (conv_wait) step();
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    check("pool_after_conv_done", pool_enable, 1);
    n = 1;
    while (!done && n < 4 * LAT) begin
      if (change && n == PC + 2) scores = ~bus;
      step();
      n++;
    end
    check("done_latency", n, LAT);
    check("result_class", result_class, cls);
    check("result_score", result_score, sc);
    step();
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("result_held", result_class, cls);
  endtask

  initial begin
    longint v[CC];
    int     ecls, n, d0;
    longint esc;
    logic [BUS-1:0] b;

    v = '{3, -7, 12, 12, 0, 0, 0, 0, 0, 0};
    tbl[0].bus = pack(v); tbl[0].cls = 2; tbl[0].score = 12;
    v = '{-5, -9, -100, -2, -3, -8, SMIN, -4, -6, -1};
    tbl[1].bus = pack(v); tbl[1].cls = 9; tbl[1].score = -1;
    v = '{-4, -4, -4, -4, -4, -4, -4, -4, -4, -4};
    tbl[2].bus = pack(v); tbl[2].cls = 0; tbl[2].score = -4;
    v = '{SMIN, SMIN, SMIN, SMIN, SMIN, SMAX, SMIN, SMIN, SMIN, SMAX};
    tbl[3].bus = pack(v); tbl[3].cls = 5; tbl[3].score = SMAX;
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[4].bus = pack(v); tbl[4].cls = 8; tbl[4].score = 1;

    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_conv_enable", conv_enable, 0);
    check("rst_pool_enable", pool_enable, 0);
    check("rst_done", done, 0);
    check("rst_result_class", result_class, 0);
    check("rst_result_score", result_score, 0);
    check("rst_error", error, 0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) run_one(tbl[i].bus, tbl[i].cls, tbl[i].score, (i == 0) ? 4 : i, 1'b0);

    // Scores disturbed after the dense capture must not change the answer.
    run_one(tbl[1].bus, tbl[1].cls, tbl[1].score, 2, 1'b1);
    run_one(tbl[4].bus, tbl[4].cls, tbl[4].score, 0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < CC; i++) v[i] = rnd_score();
      b = pack(v);
      ref_argmax(b, ecls, esc);
      run_one(b, ecls, esc, $urandom_range(0, 5), k[0]);
    end

    // Start held high: back-to-back runs, one done each, IDLE visited in between.
    d0 = done_cnt;
    scores = tbl[0].bus;
    start  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!conv_enable && n < 10) begin step(); n++; end
      check("b2b_conv_entered", conv_enable, 1);
      repeat (2) step();
      conv_done = 1'b1;
      step();
      conv_done = 1'b0;
      n = 0;
      while (!done && n < 4 * LAT) begin step(); n++; end
      check("b2b_done", done, 1);
      check("b2b_result_class", result_class, 2);
      step();
      check("b2b_idle_between", busy, 0);
      if (k == 1) start = 1'b0;
    end
    repeat (3) step();
    check("b2b_stays_idle", busy, 0);
    check("b2b_done_count", done_cnt - d0, 2);

    // Asynchronous reset in the middle of POOL.
    scores = tbl[3].bus;
    start  = 1'b1;
    step();
    start     = 1'b0;
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    check("mid_pool_enable", pool_enable, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pool_enable", pool_enable, 0);
    check("mid_rst_result_class", result_class, 0);
    check("mid_rst_result_score", result_score, 0);
    check("mid_rst_done", done, 0);
    step();
    reset = 1'b1;
    run_one(tbl[3].bus, tbl[3].cls, tbl[3].score, 1, 1'b0);

`ifdef CNN_SEQ_WATCHDOG_EN
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < TC + 20) begin step(); n++; end
    check("wd_latency", n, TC + 2);
    check("wd_error", error, 1);
    check("wd_result_class", result_class, 0);
    check("wd_result_score", result_score, 0);
    step();
    check("wd_error_holds", error, 1);
    run_one(tbl[0].bus, tbl[0].cls, tbl[0].score, 3, 1'b0);
`else
    check("error_tied_low", error, 0);
`endif

    check("no_enable_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d, expected %0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
